// File: rtl/execute_stage_ms.sv
// Registered NUM_LANES-wide execute stage: per-lane single-cycle ALU with oldest-first redirect,
// plus a lane-0 iterative MULT/DIV unit (one bit per cycle) feeding HI/LO.
module execute_stage_ms #(
    parameter int NUM_LANES  = 2,
    parameter int DWIDTH     = 32,
    parameter int PC_WIDTH   = 32,
    parameter int AWIDTH     = 5,
    parameter int IMM_WIDTH  = 16,
    parameter int JUMP_WIDTH = 26
) (
    input  logic                             es_i_clk,
    input  logic                             es_i_rst,
    input  logic                             es_i_valid,
    output logic                             es_o_ready,
    input  logic [NUM_LANES-1:0]             es_i_ce,
    input  logic [5*NUM_LANES-1:0]           es_i_ctrl,
    input  logic [NUM_LANES-1:0]             es_i_alu_src,
    input  logic [PC_WIDTH*NUM_LANES-1:0]    es_i_pc,
    input  logic [IMM_WIDTH*NUM_LANES-1:0]   es_i_imm,
    input  logic [JUMP_WIDTH*NUM_LANES-1:0]  es_i_jal_addr,
    input  logic [DWIDTH*NUM_LANES-1:0]      es_i_data_rs,
    input  logic [DWIDTH*NUM_LANES-1:0]      es_i_data_rt,
    input  logic [AWIDTH*NUM_LANES-1:0]      es_i_addr_rd,
    output logic                             es_o_valid,
    input  logic                             es_i_ready,
    output logic [NUM_LANES-1:0]             es_o_ce,
    output logic [DWIDTH*NUM_LANES-1:0]      es_o_alu_value,
    output logic [AWIDTH*NUM_LANES-1:0]      es_o_addr_rd,
    output logic                             es_o_change_pc,
    output logic [PC_WIDTH-1:0]              es_o_alu_pc,
    output logic                             es_o_illegal
);
    localparam int TOPW = PC_WIDTH - JUMP_WIDTH - 2;
    localparam int CW   = $clog2(DWIDTH);
    localparam logic [PC_WIDTH-1:0] JMASK = {{TOPW{1'b1}}, {(JUMP_WIDTH+2){1'b0}}};

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB   = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4,  OP_NOR   = 5'd5,  OP_SLT  = 5'd6,  OP_SLTU = 5'd7;
    localparam logic [4:0] OP_SLL  = 5'd8,  OP_SRL   = 5'd9,  OP_SRA  = 5'd10, OP_LUI  = 5'd11;
    localparam logic [4:0] OP_JR   = 5'd12, OP_JAL   = 5'd13, OP_MULT = 5'd14, OP_MULTU = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16, OP_DIVU  = 5'd17, OP_MFHI = 5'd18, OP_MFLO = 5'd19;

    typedef enum logic {IDLE, BUSY} md_state_t;
    md_state_t state, state_nxt;

    logic [4:0]          lane_op  [NUM_LANES];
    logic [DWIDTH-1:0]   op_a     [NUM_LANES];
    logic [DWIDTH-1:0]   op_b     [NUM_LANES];
    logic [PC_WIDTH-1:0] lane_pc  [NUM_LANES];
    logic [DWIDTH-1:0]   lane_res [NUM_LANES];
    logic [PC_WIDTH-1:0] lane_tgt [NUM_LANES];
    logic [NUM_LANES-1:0] lane_ce, lane_redir, lane_ill, ce_sq;
    logic                redir_any;
    logic [PC_WIDTH-1:0] redir_tgt;
    logic                accept, stall_out, lane0_mf, md_start, md_last;
    logic [DWIDTH-1:0]   hi, lo;

    logic [2*DWIDTH-1:0] md_p, md_p_nxt, md_prod;
    logic [DWIDTH-1:0]   md_m, md_dividend, md_q, md_r, a_abs, b_abs;
    logic [CW-1:0]       md_cnt;
    logic                md_is_div, md_neg_q, md_neg_r, md_dz;
    logic                md_signed, md_div_op, a_neg, b_neg;
    logic [DWIDTH:0]     mul_sum;
    logic [DWIDTH+1:0]   div_diff;

    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_op[i] = es_i_ctrl[i*5 +: 5];
            lane_pc[i] = es_i_pc[i*PC_WIDTH +: PC_WIDTH];
            op_a[i]    = es_i_data_rs[i*DWIDTH +: DWIDTH];
            op_b[i]    = es_i_alu_src[i]
                       ? {{(DWIDTH-IMM_WIDTH){es_i_imm[i*IMM_WIDTH+IMM_WIDTH-1]}}, es_i_imm[i*IMM_WIDTH +: IMM_WIDTH]}
                       : es_i_data_rt[i*DWIDTH +: DWIDTH];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_res[i]   = '0;
            lane_tgt[i]   = '0;
            lane_ce[i]    = 1'b0;
            lane_redir[i] = 1'b0;
            lane_ill[i]   = 1'b0;
            if (es_i_ce[i]) begin
                lane_ce[i] = 1'b1;
                case (lane_op[i])
                    OP_ADD:  lane_res[i] = op_a[i] + op_b[i];
                    OP_SUB:  lane_res[i] = op_a[i] - op_b[i];
                    OP_AND:  lane_res[i] = op_a[i] & op_b[i];
                    OP_OR:   lane_res[i] = op_a[i] | op_b[i];
                    OP_XOR:  lane_res[i] = op_a[i] ^ op_b[i];
                    OP_NOR:  lane_res[i] = ~(op_a[i] | op_b[i]);
                    OP_SLT:  lane_res[i] = {{(DWIDTH-1){1'b0}}, $signed(op_a[i]) < $signed(op_b[i])};
                    OP_SLTU: lane_res[i] = {{(DWIDTH-1){1'b0}}, op_a[i] < op_b[i]};
                    OP_SLL:  lane_res[i] = op_a[i] << op_b[i][4:0];
                    OP_SRL:  lane_res[i] = op_a[i] >> op_b[i][4:0];
                    OP_SRA:  lane_res[i] = $signed(op_a[i]) >>> op_b[i][4:0];
                    OP_LUI:  lane_res[i] = op_b[i] << 16;
                    OP_JR: begin
                        lane_redir[i] = 1'b1;
                        lane_tgt[i]   = op_a[i];
                        lane_res[i]   = lane_pc[i] + PC_WIDTH'(8);
                    end
                    OP_JAL: begin
                        lane_redir[i] = 1'b1;
                        lane_tgt[i]   = ((lane_pc[i] + PC_WIDTH'(4)) & JMASK)
                                      | {{TOPW{1'b0}}, es_i_jal_addr[i*JUMP_WIDTH +: JUMP_WIDTH], 2'b00};
                        lane_res[i]   = lane_pc[i] + PC_WIDTH'(8);
                    end
                    OP_MFHI, OP_MFLO: begin
                        if (i == 0) begin
                            lane_res[i] = (lane_op[i] == OP_MFHI) ? hi : lo;
                        end else begin
                            lane_ce[i]  = 1'b0;
                            lane_ill[i] = 1'b1;
                        end
                    end
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        lane_ce[i]  = 1'b0;
                        lane_ill[i] = (i != 0);
                    end
                    default: lane_ce[i] = 1'b0;
                endcase
            end
        end
    end

    // Oldest redirecting lane wins; every younger lane is squashed.
    always_comb begin
        redir_any = 1'b0;
        redir_tgt = '0;
        ce_sq     = lane_ce;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (redir_any) begin
                ce_sq[i] = 1'b0;
            end else if (lane_redir[i]) begin
                redir_any = 1'b1;
                redir_tgt = lane_tgt[i];
            end
        end
    end

    assign stall_out  = es_o_valid & ~es_i_ready;
    assign lane0_mf   = es_i_ce[0] & ((lane_op[0] == OP_MFHI) | (lane_op[0] == OP_MFLO));
    assign es_o_ready = ~stall_out & (state == IDLE) & ~(lane0_mf & (state == BUSY));
    assign accept     = es_i_valid & es_o_ready;
    assign md_start   = accept & es_i_ce[0] & (lane_op[0] >= OP_MULT) & (lane_op[0] <= OP_DIVU);

    always_ff @(posedge es_i_clk or posedge es_i_rst) begin
        if (es_i_rst) begin
            es_o_valid     <= 1'b0;
            es_o_ce        <= '0;
            es_o_alu_value <= '0;
            es_o_addr_rd   <= '0;
            es_o_change_pc <= 1'b0;
            es_o_alu_pc    <= '0;
            es_o_illegal   <= 1'b0;
        end else begin
            es_o_change_pc <= 1'b0;
            es_o_illegal   <= 1'b0;
            if (accept) begin
                es_o_valid     <= 1'b1;
                es_o_ce        <= ce_sq;
                es_o_addr_rd   <= es_i_addr_rd;
                es_o_change_pc <= redir_any;
                es_o_illegal   <= |lane_ill;
                if (redir_any) es_o_alu_pc <= redir_tgt;
                for (int unsigned i = 0; i < NUM_LANES; i++)
                    es_o_alu_value[i*DWIDTH +: DWIDTH] <= lane_res[i];
            end else if (es_o_valid & es_i_ready) begin
                es_o_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge es_i_clk or posedge es_i_rst) begin
        if (es_i_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        md_last   = 1'b0;
        case (state)
            IDLE: if (md_start) state_nxt = BUSY;
            BUSY: if (md_cnt == CW'(DWIDTH-1)) begin
                state_nxt = IDLE;
                md_last   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Signed ops run on magnitudes; signs are reapplied when HI/LO are written.
    always_comb begin
        md_signed = (lane_op[0] == OP_MULT) | (lane_op[0] == OP_DIV);
        md_div_op = (lane_op[0] == OP_DIV) | (lane_op[0] == OP_DIVU);
        a_neg     = md_signed & op_a[0][DWIDTH-1];
        b_neg     = md_signed & op_b[0][DWIDTH-1];
        a_abs     = a_neg ? -op_a[0] : op_a[0];
        b_abs     = b_neg ? -op_b[0] : op_b[0];
        mul_sum   = {1'b0, md_p[2*DWIDTH-1:DWIDTH]} + (md_p[0] ? {1'b0, md_m} : '0);
        div_diff  = {1'b0, md_p[2*DWIDTH-1:DWIDTH-1]} - {2'b00, md_m};
        if (md_is_div)
            md_p_nxt = (|div_diff[DWIDTH+1:DWIDTH]) ? {md_p[2*DWIDTH-2:0], 1'b0}
                                                    : {div_diff[DWIDTH-1:0], md_p[DWIDTH-2:0], 1'b1};
        else
            md_p_nxt = {mul_sum, md_p[DWIDTH-1:1]};
        md_prod = md_neg_q ? -md_p_nxt : md_p_nxt;
        md_q    = md_neg_q ? -md_p_nxt[DWIDTH-1:0] : md_p_nxt[DWIDTH-1:0];
        md_r    = md_neg_r ? -md_p_nxt[2*DWIDTH-1:DWIDTH] : md_p_nxt[2*DWIDTH-1:DWIDTH];
    end

    always_ff @(posedge es_i_clk or posedge es_i_rst) begin
        if (es_i_rst) begin
            md_p        <= '0;
            md_m        <= '0;
            md_cnt      <= '0;
            md_is_div   <= 1'b0;
            md_neg_q    <= 1'b0;
            md_neg_r    <= 1'b0;
            md_dz       <= 1'b0;
            md_dividend <= '0;
            hi          <= '0;
            lo          <= '0;
        end else if (md_start) begin
            md_p        <= {{DWIDTH{1'b0}}, md_div_op ? a_abs : b_abs};
            md_m        <= md_div_op ? b_abs : a_abs;
            md_cnt      <= '0;
            md_is_div   <= md_div_op;
            md_neg_q    <= a_neg ^ b_neg;
            md_neg_r    <= a_neg;
            md_dz       <= md_div_op & (op_b[0] == '0);
            md_dividend <= op_a[0];
        end else if (state == BUSY) begin
            md_p   <= md_p_nxt;
            md_cnt <= md_cnt + CW'(1);
            if (md_last) begin
                if (!md_is_div) begin
                    {hi, lo} <= md_prod;
                end else if (md_dz) begin
                    lo <= '1;
                    hi <= md_dividend;
                end else begin
                    lo <= md_q;
                    hi <= md_r;
                end
            end
        end
    end
endmodule

// File: tb/tb_execute_stage_ms.sv
// Directed-vector bench for execute_stage_ms: ALU ops, redirects/squash, MULT/DIV corner cases,
// output hold under backpressure and reset during a busy multiply.
module tb_execute_stage_ms;
    localparam int N = 2;

    logic            es_i_clk = 1'b0;
    logic            es_i_rst;
    logic            es_i_valid, es_o_ready, es_o_valid, es_i_ready;
    logic [N-1:0]    es_i_ce, es_i_alu_src, es_o_ce;
    logic [5*N-1:0]  es_i_ctrl, es_i_addr_rd, es_o_addr_rd;
    logic [32*N-1:0] es_i_pc, es_i_data_rs, es_i_data_rt, es_o_alu_value;
    logic [16*N-1:0] es_i_imm;
    logic [26*N-1:0] es_i_jal_addr;
    logic            es_o_change_pc, es_o_illegal;
    logic [31:0]     es_o_alu_pc;

    int vectors = 0;
    int miscompares = 0;
    int cnt;
    int pulses;

    always #5 es_i_clk = ~es_i_clk;

    execute_stage_ms #(
        .NUM_LANES(N), .DWIDTH(32), .PC_WIDTH(32), .AWIDTH(5), .IMM_WIDTH(16), .JUMP_WIDTH(26)
    ) dut (
        .es_i_clk(es_i_clk), .es_i_rst(es_i_rst), .es_i_valid(es_i_valid), .es_o_ready(es_o_ready),
        .es_i_ce(es_i_ce), .es_i_ctrl(es_i_ctrl), .es_i_alu_src(es_i_alu_src), .es_i_pc(es_i_pc),
        .es_i_imm(es_i_imm), .es_i_jal_addr(es_i_jal_addr), .es_i_data_rs(es_i_data_rs),
        .es_i_data_rt(es_i_data_rt), .es_i_addr_rd(es_i_addr_rd), .es_o_valid(es_o_valid),
        .es_i_ready(es_i_ready), .es_o_ce(es_o_ce), .es_o_alu_value(es_o_alu_value),
        .es_o_addr_rd(es_o_addr_rd), .es_o_change_pc(es_o_change_pc), .es_o_alu_pc(es_o_alu_pc),
        .es_o_illegal(es_o_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_bundle();
        es_i_valid = 1'b0;  es_i_ce = '0;       es_i_ctrl = '0;     es_i_alu_src = '0;
        es_i_pc = '0;       es_i_imm = '0;      es_i_jal_addr = '0; es_i_data_rs = '0;
        es_i_data_rt = '0;  es_i_addr_rd = '0;
    endtask

    task automatic lane(input int l, input logic [4:0] op, input logic [31:0] rs, input logic [31:0] rt);
        es_i_ce[l]              = 1'b1;
        es_i_ctrl[l*5 +: 5]     = op;
        es_i_data_rs[l*32 +: 32] = rs;
        es_i_data_rt[l*32 +: 32] = rt;
        es_i_addr_rd[l*5 +: 5]  = 5'(l + 1);
    endtask

    task automatic issue();
        es_i_valid = 1'b1;
        @(posedge es_i_clk); #1;
        es_i_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int c = 0;
        while (!es_o_ready && c < 200) begin
            @(posedge es_i_clk); #1;
            c++;
        end
        chk(tag, 64'(es_o_ready), 64'd1);
    endtask

    task automatic read_hilo(input logic [4:0] op, input string tag, input logic [31:0] exp);
        wait_ready({tag, "_rdy"});
        clear_bundle();
        lane(0, op, 32'd0, 32'd0);
        issue();
        chk(tag, 64'(es_o_alu_value[31:0]), 64'(exp));
    endtask

    task automatic alu_pair(input string tag, input logic [4:0] op0, input logic src0,
                            input logic [31:0] rs0, input logic [31:0] b0, input logic [4:0] op1,
                            input logic [31:0] rs1, input logic [31:0] rt1,
                            input logic [31:0] e0, input logic [31:0] e1);
        clear_bundle();
        lane(0, op0, rs0, b0);
        if (src0) begin
            es_i_alu_src[0] = 1'b1;
            es_i_imm[15:0]  = b0[15:0];
        end
        lane(1, op1, rs1, rt1);
        issue();
        chk({tag, "_ce"}, 64'(es_o_ce), 64'd3);
        chk({tag, "_v0"}, 64'(es_o_alu_value[31:0]), 64'(e0));
        chk({tag, "_v1"}, 64'(es_o_alu_value[63:32]), 64'(e1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        es_i_rst = 1'b1;
        es_i_ready = 1'b1;
        clear_bundle();
        repeat (2) @(posedge es_i_clk);
        #1 es_i_rst = 1'b0;
        chk("rst_valid", 64'(es_o_valid), 64'd0);
        chk("rst_ce", 64'(es_o_ce), 64'd0);
        chk("rst_value", 64'(es_o_alu_value), 64'd0);
        chk("rst_chpc", 64'(es_o_change_pc), 64'd0);
        chk("rst_alu_pc", 64'(es_o_alu_pc), 64'd0);
        chk("rst_ready", 64'(es_o_ready), 64'd1);

        clear_bundle();
        lane(0, 5'd0, 32'd5, 32'd7);
        lane(1, 5'd1, 32'd3, 32'd9);
        issue();
        chk("add_valid", 64'(es_o_valid), 64'd1);
        chk("add_ce", 64'(es_o_ce), 64'd3);
        chk("add_v0", 64'(es_o_alu_value[31:0]), 64'd12);
        chk("sub_v1", 64'(es_o_alu_value[63:32]), 64'hFFFF_FFFA);
        chk("add_rd", 64'(es_o_addr_rd), 64'h41);
        chk("add_chpc", 64'(es_o_change_pc), 64'd0);
        @(posedge es_i_clk); #1;
        chk("drain_valid", 64'(es_o_valid), 64'd0);

        clear_bundle();
        lane(0, 5'd13, 32'd0, 32'd0);
        es_i_pc[31:0] = 32'h0040_0000;
        es_i_jal_addr[25:0] = 26'h100;
        lane(1, 5'd0, 32'd1, 32'd1);
        issue();
        chk("jal_chpc", 64'(es_o_change_pc), 64'd1);
        chk("jal_pc", 64'(es_o_alu_pc), 64'h400);
        chk("jal_v0", 64'(es_o_alu_value[31:0]), 64'h0040_0008);
        chk("jal_ce", 64'(es_o_ce), 64'd1);
        @(posedge es_i_clk); #1;
        chk("jal_pulse", 64'(es_o_change_pc), 64'd0);

        alu_pair("and_sra", 5'd2, 1'b1, 32'h1234_5678, 32'h0000_FFF0, 5'd10, 32'h8000_0000, 32'd4,
                 32'h1234_5670, 32'hF800_0000);
        alu_pair("slt", 5'd6, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0);
        alu_pair("lui_nor", 5'd11, 1'b1, 32'd0, 32'h0000_1234, 5'd5, 32'd0, 32'h0F0F_0F0F,
                 32'h1234_0000, 32'hF0F0_F0F0);
        alu_pair("sll_srl", 5'd8, 1'b0, 32'd1, 32'd31, 5'd9, 32'h8000_0000, 32'd31, 32'h8000_0000, 32'd1);
        alu_pair("xor_or", 5'd4, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd3, 32'hF0, 32'h0F,
                 32'hF0F0_F0F0, 32'hFF);
        alu_pair("wrap", 5'd0, 1'b1, 32'd5, 32'h0000_FFFF, 5'd1, 32'd0, 32'd1, 32'd4, 32'hFFFF_FFFF);

        clear_bundle();
        lane(0, 5'd0, 32'd1, 32'd1);
        lane(1, 5'd18, 32'd0, 32'd0);
        issue();
        chk("ill_flag", 64'(es_o_illegal), 64'd1);
        chk("ill_ce", 64'(es_o_ce), 64'd1);
        chk("ill_v0", 64'(es_o_alu_value[31:0]), 64'd2);
        @(posedge es_i_clk); #1;
        chk("ill_pulse", 64'(es_o_illegal), 64'd0);

        clear_bundle();
        lane(0, 5'd3, 32'hF0, 32'h0F);
        lane(1, 5'd12, 32'h1000, 32'd0);
        issue();
        chk("jr1_chpc", 64'(es_o_change_pc), 64'd1);
        chk("jr1_pc", 64'(es_o_alu_pc), 64'h1000);
        chk("jr1_ce", 64'(es_o_ce), 64'd3);
        chk("jr1_v0", 64'(es_o_alu_value[31:0]), 64'hFF);

        clear_bundle();
        lane(0, 5'd12, 32'h2000, 32'd0);
        lane(1, 5'd12, 32'h3000, 32'd0);
        issue();
        chk("squash_pc", 64'(es_o_alu_pc), 64'h2000);
        chk("squash_ce", 64'(es_o_ce), 64'd1);

        clear_bundle();
        lane(0, 5'd31, 32'd1, 32'd1);
        lane(1, 5'd0, 32'd1, 32'd1);
        es_i_ce[1] = 1'b0;
        issue();
        chk("nop_valid", 64'(es_o_valid), 64'd1);
        chk("nop_ce", 64'(es_o_ce), 64'd0);

        clear_bundle();
        lane(0, 5'd14, 32'hFFFF_FFFF, 32'd2);
        issue();
        chk("mult_valid", 64'(es_o_valid), 64'd1);
        chk("mult_ce", 64'(es_o_ce), 64'd0);
        clear_bundle();
        lane(0, 5'd19, 32'd0, 32'd0);
        es_i_valid = 1'b1;
        cnt = 0;
        while (!es_o_ready && cnt < 200) begin
            @(posedge es_i_clk); #1;
            cnt++;
        end
        chk("mult_busy_cycles", 64'(cnt), 64'd32);
        @(posedge es_i_clk); #1;
        es_i_valid = 1'b0;
        chk("mflo_ce", 64'(es_o_ce), 64'd1);
        chk("mflo_mult", 64'(es_o_alu_value[31:0]), 64'hFFFF_FFFE);
        read_hilo(5'd18, "mfhi_mult", 32'hFFFF_FFFF);

        clear_bundle();
        lane(0, 5'd17, 32'd7, 32'd0);
        issue();
        read_hilo(5'd19, "divu0_lo", 32'hFFFF_FFFF);
        read_hilo(5'd18, "divu0_hi", 32'd7);

        clear_bundle();
        lane(0, 5'd16, 32'h8000_0000, 32'hFFFF_FFFF);
        issue();
        read_hilo(5'd19, "divmin_lo", 32'h8000_0000);
        read_hilo(5'd18, "divmin_hi", 32'd0);

        clear_bundle();
        lane(0, 5'd16, 32'hFFFF_FFF9, 32'd2);
        issue();
        read_hilo(5'd19, "divneg_lo", 32'hFFFF_FFFD);
        read_hilo(5'd18, "divneg_hi", 32'hFFFF_FFFF);

        clear_bundle();
        lane(0, 5'd0, 32'd2, 32'd3);
        lane(1, 5'd13, 32'd0, 32'd0);
        es_i_pc[63:32] = 32'h1000_0000;
        es_i_jal_addr[51:26] = 26'h3;
        issue();
        es_i_ready = 1'b0;
        pulses = int'(es_o_change_pc);
        chk("hold_pc", 64'(es_o_alu_pc), 64'h1000_000C);
        chk("hold_ce", 64'(es_o_ce), 64'd3);
        for (int k = 0; k < 3; k++) begin
            @(posedge es_i_clk); #1;
            pulses += int'(es_o_change_pc);
            chk("hold_v0", 64'(es_o_alu_value[31:0]), 64'd5);
            chk("hold_v1", 64'(es_o_alu_value[63:32]), 64'h1000_0008);
            chk("hold_valid", 64'(es_o_valid), 64'd1);
            chk("hold_ready", 64'(es_o_ready), 64'd0);
        end
        chk("hold_pulses", 64'(pulses), 64'd1);
        es_i_ready = 1'b1;
        @(posedge es_i_clk); #1;
        chk("hold_release", 64'(es_o_valid), 64'd0);

        clear_bundle();
        lane(0, 5'd15, 32'd3, 32'd5);
        issue();
        repeat (9) @(posedge es_i_clk);
        #1;
        chk("abort_busy", 64'(es_o_ready), 64'd0);
        es_i_rst = 1'b1;
        @(posedge es_i_clk); #1;
        es_i_rst = 1'b0;
        chk("abort_valid", 64'(es_o_valid), 64'd0);
        chk("abort_ready", 64'(es_o_ready), 64'd1);
        read_hilo(5'd18, "abort_hi", 32'd0);
        read_hilo(5'd19, "abort_lo", 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
